// File: rtl/debounced_key_port.sv
// Pushbutton/switch bus port: synchronise, debounce, capture presses in a
// write-1-to-clear register and raise a maskable level interrupt.
module debounced_key_port #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] rise;
  logic [31:0]      rd_mux;
  logic             rd_sel;
  logic             wr_sel;
  logic             unused_wdata;

  // Bus protocol: read/write strobes count only while chipselect is high and
  // never stall. A write acts on the clock edge it is sampled; a read returns
  // data on readdata one cycle later, which then holds until the next read.
  assign rd_sel = chipselect & read;
  assign wr_sel = chipselect & write;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE_LEVEL;
    end else begin
      sync_q[0] <= pins_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Internally 1 always means pressed, whatever the board polarity.
  assign pressed = sync_q[SYNC_STAGES-1] ^ IDLE_LEVEL;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = pressed[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Capture uses the next debounced value so the edge bit sets together with deb.
  assign rise     = deb_d & ~deb_q;
  assign clr_bits = (wr_sel && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(deb_q);
      2'd2:    rd_mux = 32'(mask_q);
      2'd3:    rd_mux = 32'(edge_q);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q    <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      readdata <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      edge_q <= (edge_q & ~clr_bits) | rise;
      if (wr_sel && address == 2'd2) mask_q <= writedata[WIDTH-1:0];
      if (rd_sel) readdata <= rd_mux;
    end
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_debounced_key_port.sv
// Bench for debounced_key_port: directed scenarios plus random pin/bus traffic,
// checked every cycle against a window-based reference model.
module tb_debounced_key_port;
  localparam int WIDTH = 4;
  localparam int DEB   = 8;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] pins_in;
  logic [1:0]       address;
  logic             chipselect;
  logic             read;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;

  int n_cmp = 0;
  int n_bad = 0;

  debounced_key_port #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pins_in(pins_in), .address(address),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [WIDTH-1:0] m_deb;
  logic [WIDTH-1:0] m_mask;
  logic [WIDTH-1:0] m_edge;
  logic [31:0]      m_rd;
  logic [WIDTH-1:0] hist[$];   // pressed pattern seen at each clock edge

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_deb  = '0;
    m_mask = '0;
    m_edge = '0;
    m_rd   = '0;
    hist.delete();
    repeat (SYNC + DEB) hist.push_back('0);
  endtask

  // A channel's accepted state flips once the pin, seen SYNC edges late, has
  // disagreed with it for the last DEB edges in a row.
  task automatic model_step();
    logic [WIDTH-1:0] nd;
    logic [WIDTH-1:0] clr;
    logic             all_diff;
    int               len;
    if (!reset_n) begin
      model_reset();
      return;
    end
    hist.push_back(~pins_in);
    if (hist.size() > SYNC + DEB + 1) void'(hist.pop_front());
    len = hist.size();
    nd = m_deb;
    for (int i = 0; i < WIDTH; i++) begin
      all_diff = 1'b1;
      for (int k = len - SYNC - DEB; k <= len - 1 - SYNC; k++)
        if (hist[k][i] == m_deb[i]) all_diff = 1'b0;
      if (all_diff) nd[i] = ~m_deb[i];
    end
    if (chipselect && read) begin
      case (address)
        2'd0:    m_rd = {28'b0, m_deb};
        2'd1:    m_rd = 32'b0;
        2'd2:    m_rd = {28'b0, m_mask};
        default: m_rd = {28'b0, m_edge};
      endcase
    end
    clr = (chipselect && write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    m_edge = (m_edge & ~clr) | (nd & ~m_deb);
    if (chipselect && write && address == 2'd2) m_mask = writedata[WIDTH-1:0];
    m_deb = nd;
  endtask

  // scoreboard: one clock with current inputs, then compare at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("readdata", readdata, m_rd);
    check_val("irq", {31'b0, irq}, {31'b0, |(m_edge & m_mask)});
  endtask

  // driver tasks
  task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    read       = rd;
    write      = wr;
    address    = a;
    writedata  = d;
    cycle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  // Read one address every cycle until bit b shows 1; lat counts edges from the call.
  task automatic wait_read_bit(input logic [1:0] a, input int b, output int lat);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    lat        = -1;
    for (int n = 1; n <= 40; n++) begin
      cycle();
      if (readdata[b]) begin
        lat = n;
        break;
      end
    end
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  int lat;
  logic [WIDTH-1:0] tmp_pins;
  int pin_idx;

  initial begin
    reset_n    = 1'b0;
    pins_in    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'h0;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;
    cycle();

    // idle after reset: every register reads zero
    bus(1'b1, 1'b0, 2'd0, 32'h0);
    check_val("rst_deb", readdata, 32'h0);
    bus(1'b1, 1'b0, 2'd2, 32'h0);
    check_val("rst_mask", readdata, 32'h0);
    bus(1'b1, 1'b0, 2'd3, 32'h0);
    check_val("rst_edge", readdata, 32'h0);
    check_val("rst_irq", {31'b0, irq}, 32'h0);

    // clean press of key 1: deb after SYNC+DEB edges, seen on a read one edge later
    pins_in[1] = 1'b0;
    wait_read_bit(2'd0, 1, lat);
    check_val("press_latency", lat, SYNC + DEB + 1);
    bus(1'b1, 1'b0, 2'd3, 32'h0);
    check_val("press_edge", readdata, 32'h2);
    check_val("press_irq_masked", {31'b0, irq}, 32'h0);

    // bouncing key 2: only the final stable low counts
    pins_in[2] = 1'b0;
    repeat (5) cycle();
    pins_in[2] = 1'b1;
    repeat (5) cycle();
    pins_in[2] = 1'b0;
    wait_read_bit(2'd0, 2, lat);
    check_val("bounce_latency", lat, SYNC + DEB + 1);
    bus(1'b1, 1'b0, 2'd3, 32'h0);
    check_val("bounce_edge", readdata, 32'h6);

    // mask and clear
    bus(1'b0, 1'b1, 2'd2, 32'h2);
    check_val("irq_on_mask", {31'b0, irq}, 32'h1);
    bus(1'b0, 1'b1, 2'd3, 32'h2);
    check_val("irq_off_clear", {31'b0, irq}, 32'h0);
    bus(1'b1, 1'b0, 2'd3, 32'h0);
    check_val("edge_after_clear", readdata, 32'h4);

    // release of key 1 changes deb only
    pins_in[1] = 1'b1;
    repeat (SYNC + DEB + 2) cycle();
    bus(1'b1, 1'b0, 2'd0, 32'h0);
    check_val("release_deb", readdata, 32'h4);
    bus(1'b1, 1'b0, 2'd3, 32'h0);
    check_val("release_edge", readdata, 32'h4);

    // new press lands on the same edge as a clear of that bit: set wins
    pins_in[1] = 1'b0;
    repeat (SYNC + DEB - 1) cycle();
    bus(1'b0, 1'b1, 2'd3, 32'h2);
    check_val("set_wins_irq", {31'b0, irq}, 32'h1);
    bus(1'b1, 1'b0, 2'd3, 32'h0);
    check_val("set_wins_edge", readdata, 32'h6);

    // read and write together return the pre-write value
    bus(1'b1, 1'b1, 2'd3, 32'hF);
    check_val("rw_pre_value", readdata, 32'h6);
    bus(1'b1, 1'b0, 2'd1, 32'h0);
    check_val("reserved_read", readdata, 32'h0);

    // key 0 held through a reset in the middle of its count
    pins_in = 4'hF;
    repeat (SYNC + DEB + 2) cycle();
    pins_in[0] = 1'b0;
    repeat (5) cycle();
    reset_n = 1'b0;
    repeat (2) cycle();
    check_val("in_reset_rd", readdata, 32'h0);
    reset_n = 1'b1;
    wait_read_bit(2'd3, 0, lat);
    check_val("reset_press_latency", lat, SYNC + DEB + 1);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        tmp_pins = pins_in;
        pin_idx  = $urandom_range(0, WIDTH - 1);
        tmp_pins[pin_idx] = ~tmp_pins[pin_idx];
        pins_in = tmp_pins;
      end
      chipselect = ($urandom_range(0, 2) != 0);
      read       = $urandom_range(0, 1);
      write      = ($urandom_range(0, 3) == 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      reset_n    = (c % 1000 != 999);
      cycle();
    end
    reset_n    = 1'b1;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    cycle();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
